int_root: RTL and testbench
===========================

# int_root

Parametrised iterative integer root engine: computes floor(sqrt(x)) or floor(cbrt(x)) of a W-bit unsigned operand, selected per request. Uses the digit-by-digit restoring method, one result bit per iteration. A shared sequential multiplier is used for the cube term. Sits beside the existing datapath blocks behind the same start/busy handshake, and replaces the fixed 8-bit cube-root unit.

## Interface
- W, 8: operand width in bits, W ≥ 2.
- RW, derived (W+1)/2: result width, sized for sqrt; cube results are zero-extended.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- x_bi  in  W  unsigned operand, sampled on accepted start.
- mode_i  in  1  0 = square root, 1 = cube root, sampled on accepted start.
- start_i  in  1  request; accepted only in IDLE.
- busy_o  out  1  high while computing; reset value 0.
- y_bo  out  RW  last result, held until the next completion; reset value 0.
- rem_bo  out  W  x − y^mode; present only with INT_ROOT_REM_EN; reset value 0.

## Operation
- States: IDLE, PREP, MUL_GO, MUL_WAIT, BUILD, CMP, UPDATE, NEXT.
- IDLE with start_i = 1:
  - Capture x ← x_bi and mode ← mode_i.
  - Set y ← 0.
  - Set s ← 2·((W+1)/2 − 1) for sqrt, or 3·((W+2)/3 − 1) for cbrt.
  - Go to PREP.
- PREP: y ← 2y. For sqrt, go to BUILD. For cbrt, go to MUL_GO.
- MUL_GO: pulse the multiplier start with operands y and y+1.
- MUL_WAIT: stay until multiplier busy is low, then latch the product p.
- BUILD:
  - sqrt: b ← (2y+1) << s.
  - cbrt: b ← (3p+1) << s.
  - b is held at 2W+2 bits; no truncation.
- CMP: flag ← (x ≥ b), with x zero-extended.
- UPDATE: if flag is set, x ← x − b and y ← y+1, in the same cycle.
- NEXT:
  - If s == 0: y_bo ← y, rem_bo ← x, go to IDLE.
  - Otherwise: s ← s − 2 (sqrt) or s − 3 (cbrt), go to PREP.
- start_i while busy is ignored. Input changes after acceptance have no effect.
- x = 0 gives y = 0, rem = 0.
- Reset at any point:
  - State goes to IDLE.
  - busy_o, y_bo and rem_bo go to 0.
  - The multiplier is reset.
  - An in-flight result is discarded.

## Timing
- busy_o rises on the edge after an accepted start.
- busy_o falls on the same edge that writes y_bo/rem_bo.
- sqrt: 5 cycles per iteration, (W+1)/2 iterations. W=8: busy high 20 cycles.
- cbrt:
  - MUL_WAIT lasts exactly RW+1 cycles, so an iteration is RW+7 cycles.
  - Iteration count is (W+2)/3.
  - W=8: 3 × 11 = 33 cycles.
- Back-to-back operation: start asserted in the first IDLE cycle is accepted. Minimum gap between jobs is 1 idle cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- INT_ROOT_REM_EN defined: rem_bo port exists, carrying the final residual x.
- Undefined:
  - rem_bo port is absent.
  - Residual is still computed internally.
  - Latency is identical.

## Structure
- Package int_root_pkg holds:
  - State enum.
  - Mode constants MODE_SQRT = 1'b0 and MODE_CBRT = 1'b1.
  - Functions for RW, iteration count and initial shift as functions of W and mode.
- Sub-module seq_mult #(WIDTH = RW+1):
  - Shift-add multiplier with clk_i/rst_i/start_i/busy_o.
  - 2·WIDTH-bit product.
  - busy high WIDTH cycles after start.
  - Instantiated once; idle in sqrt mode.

## Test plan
- W=8, sqrt of 200 → y_bo = 14, rem_bo = 4, busy high exactly 20 cycles.
- W=8, cbrt of 255 → y_bo = 6, rem_bo = 39. Cbrt of 27 → 3, rem 0. busy high 33 cycles each.
- Exhaustive W=8, both modes, x = 0..255:
  - y² ≤ x < (y+1)² for sqrt.
  - y³ ≤ x < (y+1)³ for cbrt.
- start_i pulsed mid-operation with a different x/mode → ignored; the original result is delivered.
- rst_i asserted in MUL_WAIT → next cycle IDLE, busy_o = 0, y_bo = 0. A subsequent cbrt of 64 returns 4.
- W=16 build: sqrt of 65535 → 255, rem 510. Cbrt of 65535 → 40, rem 1535. Latencies match the formulas above.

Source files
------------

// File: rtl/int_root_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_root_pkg
//  Brief    : Shared types, mode constants and sizing helpers for int_root.
//  Revision : 1.0 - initial release
// ============================================================================
package int_root_pkg;

    // Sequencer states, one result bit is produced per PREP..NEXT pass
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREP     = 3'd1,
        ST_MUL_GO   = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_BUILD    = 3'd4,
        ST_CMP      = 3'd5,
        ST_UPDATE   = 3'd6,
        ST_NEXT     = 3'd7
    } state_t;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    // Result width; sized for sqrt, cube results are narrower
    function automatic int root_width(input int w);
        return (w + 1) / 2;
    endfunction

    // Number of digit iterations for an operand of w bits
    function automatic int iter_count(input int w, input logic mode);
        return (mode == MODE_CBRT) ? (w + 2) / 3 : (w + 1) / 2;
    endfunction

    // Shift applied to the trial term on the first iteration
    function automatic int init_shift(input int w, input logic mode);
        return (mode == MODE_CBRT) ? 3 * (iter_count(w, mode) - 1)
                                   : 2 * (iter_count(w, mode) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_root_if.sv
`default_nettype none
// ============================================================================
//  Module   : int_root_if
//  Brief    : Request/result bundle for int_root. rem_bo exists only when
//             INT_ROOT_REM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface int_root_if #(
    parameter int W = 8
);
    import int_root_pkg::*;

    localparam int c_RW = root_width(W);

    logic [W-1:0]    x_bi;
    logic            mode_i;
    logic            start_i;
    logic            busy_o;
    logic [c_RW-1:0] y_bo;
`ifdef INT_ROOT_REM_EN
    logic [W-1:0]    rem_bo;
`endif

    // Requester side
    modport master (
        output x_bi, mode_i, start_i,
`ifdef INT_ROOT_REM_EN
        input  rem_bo,
`endif
        input  busy_o, y_bo
    );

    // Engine side
    modport slave (
        input  x_bi, mode_i, start_i,
`ifdef INT_ROOT_REM_EN
        output rem_bo,
`endif
        output busy_o, y_bo
    );

endinterface
`default_nettype wire

// File: rtl/int_root_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult
//  Brief    : Shift-add unsigned multiplier, one multiplier bit per cycle.
//             busy_o is high for exactly WIDTH cycles after an accepted start;
//             p_bo is valid once busy_o is low again.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult #(
    parameter int WIDTH = 5
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 start_i,
    input  wire logic [WIDTH-1:0]     a_bi,
    input  wire logic [WIDTH-1:0]     b_bi,
    output logic                      busy_o,
    output logic [2*WIDTH-1:0]        p_bo
);
    localparam int c_CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic               r_busy;

    // Load on start when idle, otherwise add/shift one bit per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (start_i) begin
                r_a    <= (2*WIDTH)'(a_bi);
                r_b    <= b_bi;
                r_acc  <= '0;
                r_cnt  <= c_CW'(WIDTH);
                r_busy <= 1'b1;
            end
        end else begin
            if (r_b[0]) begin
                r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - c_CW'(1);
            if (r_cnt == c_CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy_o = r_busy;
    assign p_bo   = r_acc;

endmodule
`default_nettype wire

// File: rtl/int_root.sv
`default_nettype none
// ============================================================================
//  Module   : int_root
//  Brief    : Iterative floor(sqrt(x)) / floor(cbrt(x)) engine, restoring
//             digit-by-digit, one result bit per iteration. Cube term y(y+1)
//             comes from a shared sequential multiplier.
//             Optional macro INT_ROOT_REM_EN exposes the final residual on
//             rem_bo; without it the residual stays internal.
//  Revision : 1.0 - initial release
// ============================================================================
module int_root
    import int_root_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    int_root_if.slave  bus
);
    localparam int c_RW = root_width(W);
    localparam int c_MW = c_RW + 1;           // multiplier operand width
    localparam int c_PW = 2 * c_MW;           // product width
    localparam int c_BW = 2 * W + 2;          // trial term width, never truncated
    localparam int c_SW = $clog2(W + 1) + 1;  // shift amount width

    localparam logic [c_SW-1:0] c_S0_SQRT = c_SW'(init_shift(W, MODE_SQRT));
    localparam logic [c_SW-1:0] c_S0_CBRT = c_SW'(init_shift(W, MODE_CBRT));

    state_t            r_state;
    logic              r_mode;
    logic [W-1:0]      r_x;
    logic [c_RW-1:0]   r_y;
    logic [c_SW-1:0]   r_s;
    logic [c_PW-1:0]   r_p;
    logic [c_BW-1:0]   r_b;
    logic              r_flag;
    logic              r_busy;
    logic [c_RW-1:0]   r_y_out;
`ifdef INT_ROOT_REM_EN
    logic [W-1:0]      r_rem;
`endif

    logic              w_mul_start;
    logic              w_mul_busy;
    logic [c_PW-1:0]   w_mul_p;
    logic [c_BW-1:0]   w_p_ext;

    // The multiply is launched from PREP using the already-doubled operands
    // {y,0} and {y,1}; its first busy cycle overlaps MUL_GO so that MUL_WAIT
    // lasts exactly RW+1 cycles.
    assign w_mul_start = (r_state == ST_PREP) && (r_mode == MODE_CBRT);
    assign w_p_ext     = c_BW'(r_p);

    seq_mult #(
        .WIDTH (c_MW)
    ) u_mult (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_mul_start),
        .a_bi    ({r_y, 1'b0}),
        .b_bi    ({r_y, 1'b1}),
        .busy_o  (w_mul_busy),
        .p_bo    (w_mul_p)
    );

    // Root sequencer: accept, iterate one digit per pass, publish result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SQRT;
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_p     <= '0;
            r_b     <= '0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
            r_y_out <= '0;
`ifdef INT_ROOT_REM_EN
            r_rem   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_x     <= bus.x_bi;
                        r_mode  <= bus.mode_i;
                        r_y     <= '0;
                        r_s     <= (bus.mode_i == MODE_CBRT) ? c_S0_CBRT : c_S0_SQRT;
                        r_busy  <= 1'b1;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_y     <= r_y << 1;
                    r_state <= (r_mode == MODE_CBRT) ? ST_MUL_GO : ST_BUILD;
                end
                ST_MUL_GO: begin
                    r_state <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (!w_mul_busy) begin
                        r_p     <= w_mul_p;
                        r_state <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    if (r_mode == MODE_CBRT) begin
                        r_b <= ((w_p_ext << 1) + w_p_ext + c_BW'(1)) << r_s;
                    end else begin
                        r_b <= c_BW'({r_y, 1'b1}) << r_s;
                    end
                    r_state <= ST_CMP;
                end
                ST_CMP: begin
                    r_flag  <= (c_BW'(r_x) >= r_b);
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    // b <= x here, so its low W bits carry the whole value
                    if (r_flag) begin
                        r_x <= r_x - r_b[W-1:0];
                        r_y <= r_y + c_RW'(1);
                    end
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (r_s == '0) begin
                        r_y_out <= r_y;
`ifdef INT_ROOT_REM_EN
                        r_rem   <= r_x;
`endif
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_s     <= r_s - ((r_mode == MODE_CBRT) ? c_SW'(3) : c_SW'(2));
                        r_state <= ST_PREP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.y_bo   = r_y_out;
`ifdef INT_ROOT_REM_EN
    assign bus.rem_bo = r_rem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_root.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_root
//  Brief    : Self-checking bench for int_root (W = 8), reference roots and
//             latencies derived from plain arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_root;
    import int_root_pkg::*;

    localparam int W  = 8;
    localparam int RW = (W + 1) / 2;
    localparam int LAT_SQRT = ((W + 1) / 2) * 5;
    localparam int LAT_CBRT = ((W + 2) / 3) * (RW + 7);

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int_root_if #(.W(W)) ifc ();

    int_root #(.W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: largest y with y^k <= x, found by counting up
    function automatic int ref_root(input int x, input logic m);
        longint y;
        y = 0;
        while (((m == MODE_CBRT) ? (y + 1) * (y + 1) * (y + 1) : (y + 1) * (y + 1)) <= x)
            y++;
        return int'(y);
    endfunction

    function automatic int ref_pow(input int y, input logic m);
        return (m == MODE_CBRT) ? y * y * y : y * y;
    endfunction

    // Present a request for one cycle, then scramble the inputs
    task automatic launch(input int x, input logic m);
        ifc.x_bi    = W'(x);
        ifc.mode_i  = m;
        ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.x_bi    = W'($urandom);
        ifc.mode_i  = 1'($urandom);
    endtask

    // Count busy cycles from the current negedge until busy drops
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (ifc.busy_o === 1'b1 && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 1000) begin
            total++;
            bad++;
            $display("FAIL timeout: busy still high after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ifc.busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy_o);
        end
        total++;
        if (ifc.y_bo !== RW'(0)) begin
            bad++; $display("FAIL reset_y: got %0d want 0", ifc.y_bo);
        end
`ifdef INT_ROOT_REM_EN
        total++;
        if (ifc.rem_bo !== W'(0)) begin
            bad++; $display("FAIL reset_rem: got %0d want 0", ifc.rem_bo);
        end
`endif
    endtask

    // One full job with result, residual and latency checks
    task automatic run_check(input string nm, input int x, input logic m);
        int cyc, ey, el;
        ey = ref_root(x, m);
        el = (m == MODE_CBRT) ? LAT_CBRT : LAT_SQRT;
        launch(x, m);
        wait_done(cyc);
        total++;
        if (ifc.y_bo !== RW'(ey)) begin
            bad++; $display("FAIL %s_y: x=%0d mode=%0d got %0d want %0d", nm, x, m, ifc.y_bo, ey);
        end
        total++;
        if (cyc != el) begin
            bad++; $display("FAIL %s_lat: x=%0d mode=%0d got %0d want %0d", nm, x, m, cyc, el);
        end
`ifdef INT_ROOT_REM_EN
        total++;
        if (ifc.rem_bo !== W'(x - ref_pow(ey, m))) begin
            bad++; $display("FAIL %s_rem: x=%0d mode=%0d got %0d want %0d", nm, x, m, ifc.rem_bo, x - ref_pow(ey, m));
        end
`endif
    endtask

    task automatic test_directed;
        run_check("sqrt200", 200, MODE_SQRT);
        total++;
        if (ifc.y_bo !== RW'(14)) begin
            bad++; $display("FAIL sqrt200_const: got %0d want 14", ifc.y_bo);
        end
        run_check("cbrt255", 255, MODE_CBRT);
        total++;
        if (ifc.y_bo !== RW'(6)) begin
            bad++; $display("FAIL cbrt255_const: got %0d want 6", ifc.y_bo);
        end
        run_check("cbrt27", 27, MODE_CBRT);
        run_check("sqrt0", 0, MODE_SQRT);
        run_check("cbrt0", 0, MODE_CBRT);
    endtask

    task automatic test_exhaustive;
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < (1 << W); x++)
                run_check("exh", x, 1'(m));
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_check("rand", int'($urandom_range(0, (1 << W) - 1)), 1'($urandom));
    endtask

    task automatic test_ignore_start;
        int cyc;
        launch(255, MODE_CBRT);
        repeat (3) @(negedge clk);
        ifc.x_bi    = W'(27);
        ifc.mode_i  = MODE_SQRT;
        ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        wait_done(cyc);
        cyc += 4;
        total++;
        if (ifc.y_bo !== RW'(6)) begin
            bad++; $display("FAIL ignore_y: got %0d want 6", ifc.y_bo);
        end
        total++;
        if (cyc != LAT_CBRT) begin
            bad++; $display("FAIL ignore_lat: got %0d want %0d", cyc, LAT_CBRT);
        end
    endtask

    task automatic test_reset_midop;
        launch(255, MODE_CBRT);
        repeat (2) @(negedge clk);   // now in the multiplier wait
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (ifc.busy_o !== 1'b0) begin
            bad++; $display("FAIL midrst_busy: got %b want 0", ifc.busy_o);
        end
        total++;
        if (ifc.y_bo !== RW'(0)) begin
            bad++; $display("FAIL midrst_y: got %0d want 0", ifc.y_bo);
        end
        run_check("after_rst", 64, MODE_CBRT);
        total++;
        if (ifc.y_bo !== RW'(4)) begin
            bad++; $display("FAIL after_rst_const: got %0d want 4", ifc.y_bo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_check("b2b_a", 150, MODE_SQRT);
        // Start in the very first idle cycle must be taken
        launch(100, MODE_CBRT);
        total++;
        if (ifc.busy_o !== 1'b1) begin
            bad++; $display("FAIL b2b_accept: busy got %b want 1", ifc.busy_o);
        end
        wait_done(cyc);
        total++;
        if (ifc.y_bo !== RW'(ref_root(100, MODE_CBRT))) begin
            bad++; $display("FAIL b2b_y: got %0d want %0d", ifc.y_bo, ref_root(100, MODE_CBRT));
        end
        total++;
        if (cyc != LAT_CBRT) begin
            bad++; $display("FAIL b2b_lat: got %0d want %0d", cyc, LAT_CBRT);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        ifc.x_bi    = '0;
        ifc.mode_i  = 1'b0;
        ifc.start_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        test_random();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
